zube_fifo_mailbox: RTL and testbench

//  Next-generation Z80<->Wishbone mailbox. Replaces single-byte registers with two

---
 rtl/zube_fifo_mailbox.sv | 249 ++++++++++++++++++++++++
 tb/tb_zube_fifo_mailbox.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zube_fifo_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : zube_fifo_mailbox
// Purpose  : Z80 <-> Wishbone mailbox built from two byte FIFOs.
//            RX carries Z80 -> host bytes, TX carries host -> Z80 bytes.
//            It provides per-FIFO levels, sticky error flags and a maskable
//            level interrupt.
// Ports    : clk, reset (sync, active-high)
//            Z80 side : z80_write_strobe_b, z80_read_strobe_b, z80_ioreq_b,
//                       z80_m1, z80_address_bus[7:0], z80_data_bus_in[7:0],
//                       z80_data_bus_out[7:0], z80_bus_dir
//            WB side  : wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in[31:0],
//                       wb_data_in[31:0], wb_ack_out, wb_data_out[31:0]
//            irq_out  : |(pending & enable)
// Options  : ZUBE_FIFO_THRESHOLD_EN adds the THRESH register at +16 and the
//            RX-level threshold interrupt (pending/enable bit 3).
// Revision : 1.0  initial release
// ============================================================================
module zube_fifo_mailbox #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [7:0]  Z80_BASE_RESET = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        z80_write_strobe_b,
    input  logic        z80_read_strobe_b,
    input  logic        z80_ioreq_b,
    input  logic        z80_m1,
    input  logic [7:0]  z80_address_bus,
    input  logic [7:0]  z80_data_bus_in,
    output logic [7:0]  z80_data_bus_out,
    output logic        z80_bus_dir,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic [31:0] wb_data_out,
    output logic        irq_out
);
    localparam int              c_AW   = $clog2(FIFO_DEPTH);
    localparam int              c_LW   = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(FIFO_DEPTH);

    // ---------------- Z80 strobe/address/data synchronisers ----------------
    logic       w_io_rd, w_io_wr;
    logic       r_rd_s1, r_rd_s2, r_rd_d, r_wr_s1, r_wr_s2, r_wr_d;
    logic [7:0] r_addr_s1, r_addr_s2, r_data_s1, r_data_s2;

    assign w_io_rd = z80_m1 & ~z80_ioreq_b & ~z80_read_strobe_b;
    assign w_io_wr = z80_m1 & ~z80_ioreq_b & ~z80_write_strobe_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_s1 <= 1'b0; r_rd_s2 <= 1'b0; r_rd_d <= 1'b0;
            r_wr_s1 <= 1'b0; r_wr_s2 <= 1'b0; r_wr_d <= 1'b0;
            r_addr_s1 <= '0; r_addr_s2 <= '0;
            r_data_s1 <= '0; r_data_s2 <= '0;
        end else begin
            r_rd_s1 <= w_io_rd; r_rd_s2 <= r_rd_s1; r_rd_d <= r_rd_s2;
            r_wr_s1 <= w_io_wr; r_wr_s2 <= r_wr_s1; r_wr_d <= r_wr_s2;
            r_addr_s1 <= z80_address_bus; r_addr_s2 <= r_addr_s1;
            r_data_s1 <= z80_data_bus_in; r_data_s2 <= r_data_s1;
        end
    end

    // One access per Z80 strobe: act only on the synced rising edge.
    logic       w_rd_edge, w_wr_edge, w_z_hit_data, w_z_hit_stat;
    logic [7:0] r_base;
    assign w_rd_edge    = r_rd_s2 & ~r_rd_d;
    assign w_wr_edge    = r_wr_s2 & ~r_wr_d;
    assign w_z_hit_data = (r_addr_s2 == r_base);
    assign w_z_hit_stat = (r_addr_s2 == (r_base + 8'd1));

    // ---------------- Wishbone decode ----------------
    logic w_sel_base, w_sel_data, w_sel_stat, w_sel_irq, w_sel_thr;
    logic w_wb_hit, w_wb_act, w_wb_wr, w_wb_rd;
    assign w_sel_base = (wb_addr_in == BASE_ADDRESS);
    assign w_sel_data = (wb_addr_in == BASE_ADDRESS + 32'd4);
    assign w_sel_stat = (wb_addr_in == BASE_ADDRESS + 32'd8);
    assign w_sel_irq  = (wb_addr_in == BASE_ADDRESS + 32'd12);
`ifdef ZUBE_FIFO_THRESHOLD_EN
    assign w_sel_thr  = (wb_addr_in == BASE_ADDRESS + 32'd16);
`else
    assign w_sel_thr  = 1'b0;
`endif
    assign w_wb_hit = wb_cyc_in & wb_stb_in &
                      (w_sel_base | w_sel_data | w_sel_stat | w_sel_irq | w_sel_thr);
    // Side effects only on the first cycle of a hit (before ack goes out).
    assign w_wb_act = w_wb_hit & ~wb_ack_out;
    assign w_wb_wr  = w_wb_act & wb_we_in;
    assign w_wb_rd  = w_wb_act & ~wb_we_in;

    // ---------------- FIFOs ----------------
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [c_LW-1:0] r_rx_level, r_tx_level, w_rx_level_nxt, w_tx_level_nxt;
    logic            w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic            w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic            w_z_push_req, w_z_pop_req, w_wb_push_req, w_wb_pop_req;

    assign w_rx_full  = (r_rx_level == c_FULL);
    assign w_rx_empty = (r_rx_level == '0);
    assign w_tx_full  = (r_tx_level == c_FULL);
    assign w_tx_empty = (r_tx_level == '0);

    assign w_z_push_req  = w_wr_edge & w_z_hit_data;
    assign w_z_pop_req   = w_rd_edge & w_z_hit_data;
    assign w_wb_push_req = w_wb_wr & w_sel_data;
    assign w_wb_pop_req  = w_wb_rd & w_sel_data;

    // Acceptance is judged on the level at the start of the cycle.
    assign w_rx_push = w_z_push_req  & ~w_rx_full;
    assign w_rx_pop  = w_wb_pop_req  & ~w_rx_empty;
    assign w_tx_push = w_wb_push_req & ~w_tx_full;
    assign w_tx_pop  = w_z_pop_req   & ~w_tx_empty;

    always_comb begin
        w_rx_level_nxt = r_rx_level;
        if (w_rx_push && !w_rx_pop)      w_rx_level_nxt = r_rx_level + c_LW'(1);
        else if (!w_rx_push && w_rx_pop) w_rx_level_nxt = r_rx_level - c_LW'(1);
        w_tx_level_nxt = r_tx_level;
        if (w_tx_push && !w_tx_pop)      w_tx_level_nxt = r_tx_level + c_LW'(1);
        else if (!w_tx_push && w_tx_pop) w_tx_level_nxt = r_tx_level - c_LW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_data_s2;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wb_data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_level <= '0;
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_level <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_AW'(1);
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_AW'(1);
            r_rx_level <= w_rx_level_nxt;
            r_tx_level <= w_tx_level_nxt;
        end
    end

    logic [7:0] w_rx_lvl8, w_tx_lvl8, w_z_status;
    assign w_rx_lvl8  = 8'(r_rx_level);
    assign w_tx_lvl8  = 8'(r_tx_level);
    assign w_z_status = {4'b0, w_rx_empty, w_tx_full, w_rx_full, ~w_tx_empty};

    // ---------------- Z80 read-data driver ----------------
    logic r_driven;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_driven         <= 1'b0;
            z80_data_bus_out <= '0;
        end else if (w_rd_edge && w_z_hit_data) begin
            r_driven         <= 1'b1;
            z80_data_bus_out <= w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rp];
        end else if (w_rd_edge && w_z_hit_stat) begin
            r_driven         <= 1'b1;
            z80_data_bus_out <= w_z_status;
        end else if (!r_rd_s2) begin
            r_driven         <= 1'b0;
            z80_data_bus_out <= '0;
        end
    end
    // Raw RD_n gates the transceiver so it releases the bus immediately.
    assign z80_bus_dir = r_driven & ~z80_read_strobe_b;

    // ---------------- Errors and interrupts ----------------
    logic       w_set_under, w_set_rx_ovf, w_set_tx_ovf, w_stat_w1c, w_irq_wr, w_thr_set;
    logic       r_err_under, r_err_tx_ovf, r_err_rx_ovf;
    logic [3:0] r_pend, r_en, w_pend_set, w_pend_clr, w_en_wr;
    logic [7:0] r_thresh;

    assign w_set_under  = w_z_pop_req & w_tx_empty;
    assign w_set_rx_ovf = w_z_push_req & w_rx_full;
    assign w_set_tx_ovf = w_wb_push_req & w_tx_full;
    assign w_stat_w1c   = w_wb_wr & w_sel_stat;
    assign w_irq_wr     = w_wb_wr & w_sel_irq;

`ifdef ZUBE_FIFO_THRESHOLD_EN
    // Fires only on the cycle the RX level crosses up to the threshold.
    assign w_thr_set = (r_thresh != 8'd0) && (w_rx_lvl8 < r_thresh) &&
                       (8'(w_rx_level_nxt) >= r_thresh);
    assign w_en_wr   = wb_data_in[11:8];
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, wb_data_in[31:19], wb_data_in[15:12]};
`else
    assign w_thr_set = 1'b0;
    assign w_en_wr   = {1'b0, wb_data_in[10:8]};
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, wb_data_in[31:19], wb_data_in[15:11], r_thresh};
`endif

    assign w_pend_set = {w_thr_set, w_set_under | w_set_rx_ovf | w_set_tx_ovf,
                         w_tx_pop, w_rx_push};
    assign w_pend_clr = w_irq_wr ? wb_data_in[3:0] : 4'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_under  <= 1'b0;
            r_err_tx_ovf <= 1'b0;
            r_err_rx_ovf <= 1'b0;
            r_pend       <= '0;
            r_en         <= '0;
        end else begin
            r_err_under  <= w_set_under  | (r_err_under  & ~(w_stat_w1c & wb_data_in[18]));
            r_err_tx_ovf <= w_set_tx_ovf | (r_err_tx_ovf & ~(w_stat_w1c & wb_data_in[17]));
            r_err_rx_ovf <= w_set_rx_ovf | (r_err_rx_ovf & ~(w_stat_w1c & wb_data_in[16]));
            r_pend       <= w_pend_set | (r_pend & ~w_pend_clr);
            if (w_irq_wr) r_en <= w_en_wr;
        end
    end
    assign irq_out = |(r_pend & r_en);

    // ---------------- Wishbone register file ----------------
    logic [31:0] w_rd_data;
    always_comb begin
        w_rd_data = '0;
        if (w_sel_base)      w_rd_data = {24'b0, r_base};
        else if (w_sel_data) w_rd_data = w_rx_empty ? 32'd0 : {23'b0, 1'b1, r_rx_mem[r_rx_rp]};
        else if (w_sel_stat) w_rd_data = {13'b0, r_err_under, r_err_tx_ovf, r_err_rx_ovf,
                                          w_tx_lvl8, w_rx_lvl8};
        else if (w_sel_irq)  w_rd_data = {20'b0, r_en, 4'b0, r_pend};
        else if (w_sel_thr)  w_rd_data = {24'b0, r_thresh};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_out  <= 1'b0;
            wb_data_out <= '0;
            r_base      <= Z80_BASE_RESET;
            r_thresh    <= '0;
        end else begin
            wb_ack_out <= w_wb_hit & ~wb_ack_out;
            if (w_wb_rd) wb_data_out <= w_rd_data;
            if (w_wb_wr && w_sel_base) r_base <= wb_data_in[7:0];
`ifdef ZUBE_FIFO_THRESHOLD_EN
            if (w_wb_wr && w_sel_thr) r_thresh <= wb_data_in[7:0];
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_zube_fifo_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_zube_fifo_mailbox
// Purpose  : Self-checking bench for zube_fifo_mailbox. A queue-based model
//            of both FIFOs, sticky errors and IRQ state predicts every value.
// Revision : 1.0  initial release
// ============================================================================
module tb_zube_fifo_mailbox;
    localparam logic [31:0] c_BASE  = 32'h3000_0000;
    localparam logic [31:0] c_A_ZB  = c_BASE;
    localparam logic [31:0] c_A_DAT = c_BASE + 32'd4;
    localparam logic [31:0] c_A_STA = c_BASE + 32'd8;
    localparam logic [31:0] c_A_IRQ = c_BASE + 32'd12;
    localparam logic [31:0] c_A_THR = c_BASE + 32'd16;
    localparam int          c_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        z80_write_strobe_b = 1'b1, z80_read_strobe_b = 1'b1;
    logic        z80_ioreq_b = 1'b1, z80_m1 = 1'b1;
    logic [7:0]  z80_address_bus = '0, z80_data_bus_in = '0;
    logic [7:0]  z80_data_bus_out;
    logic        z80_bus_dir;
    logic        wb_cyc_in = 1'b0, wb_stb_in = 1'b0, wb_we_in = 1'b0;
    logic [31:0] wb_addr_in = '0, wb_data_in = '0;
    logic        wb_ack_out;
    logic [31:0] wb_data_out;
    logic        irq_out;

    always #5 clk = ~clk;

    zube_fifo_mailbox #(
        .BASE_ADDRESS(c_BASE), .FIFO_DEPTH(c_DEPTH), .Z80_BASE_RESET(8'h80)
    ) dut (
        .clk(clk), .reset(reset),
        .z80_write_strobe_b(z80_write_strobe_b), .z80_read_strobe_b(z80_read_strobe_b),
        .z80_ioreq_b(z80_ioreq_b), .z80_m1(z80_m1),
        .z80_address_bus(z80_address_bus), .z80_data_bus_in(z80_data_bus_in),
        .z80_data_bus_out(z80_data_bus_out), .z80_bus_dir(z80_bus_dir),
        .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
        .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out), .irq_out(irq_out)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_under, m_txovf, m_rxovf;
    logic [2:0] m_pend, m_en;

    task automatic model_reset();
        rx_q.delete(); tx_q.delete();
        m_under = 0; m_txovf = 0; m_rxovf = 0; m_pend = 0; m_en = 0;
    endtask

    task automatic m_zwrite(input logic [7:0] b);
        if (rx_q.size() < c_DEPTH) begin rx_q.push_back(b); m_pend[0] = 1; end
        else begin m_rxovf = 1; m_pend[2] = 1; end
    endtask

    task automatic m_zread(output logic [7:0] e);
        if (tx_q.size() > 0) begin e = tx_q.pop_front(); m_pend[1] = 1; end
        else begin e = 8'hFF; m_under = 1; m_pend[2] = 1; end
    endtask

    task automatic m_wbwrite(input logic [7:0] b);
        if (tx_q.size() < c_DEPTH) tx_q.push_back(b);
        else begin m_txovf = 1; m_pend[2] = 1; end
    endtask

    task automatic m_wbread(output logic [31:0] e);
        if (rx_q.size() > 0) e = {23'b0, 1'b1, rx_q.pop_front()};
        else e = 32'd0;
    endtask

    function automatic logic [31:0] exp_status();
        return {13'b0, m_under, m_txovf, m_rxovf, 8'(tx_q.size()), 8'(rx_q.size())};
    endfunction

    function automatic logic [7:0] exp_zstatus();
        return {4'b0, rx_q.size() == 0, tx_q.size() == c_DEPTH,
                rx_q.size() == c_DEPTH, tx_q.size() != 0};
    endfunction

    function automatic logic [31:0] exp_irq();
        return {21'b0, m_en, 5'b0, m_pend};
    endfunction

    // ---------------- bus drivers ----------------
    task automatic do_reset();
        reset = 1;
        z80_write_strobe_b = 1; z80_read_strobe_b = 1; z80_ioreq_b = 1;
        wb_cyc_in = 0; wb_stb_in = 0; wb_we_in = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_reset();
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic acked);
        wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = we; wb_addr_in = addr; wb_data_in = data;
        acked = 0; rdata = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (wb_ack_out) begin acked = 1; rdata = wb_data_out; break; end
        end
        wb_cyc_in = 0; wb_stb_in = 0; wb_we_in = 0;
    endtask

    task automatic wb_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d; logic a;
        wb_xfer(1'b1, addr, data, d, a);
    endtask

    task automatic wb_rd(input logic [31:0] addr, output logic [31:0] data);
        logic a;
        wb_xfer(1'b0, addr, 32'd0, data, a);
    endtask

    task automatic z80_io(input logic is_rd, input logic [7:0] addr, input logic [7:0] data,
                          output logic [7:0] rd_data, output logic dir_seen);
        z80_address_bus = addr; z80_data_bus_in = data; z80_m1 = 1; z80_ioreq_b = 0;
        if (is_rd) z80_read_strobe_b = 0; else z80_write_strobe_b = 0;
        repeat (6) @(posedge clk);
        #1 rd_data = z80_data_bus_out; dir_seen = z80_bus_dir;
        z80_read_strobe_b = 1; z80_write_strobe_b = 1; z80_ioreq_b = 1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic z80_wr(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] d; logic s;
        z80_io(1'b0, addr, data, d, s);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (wb_ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", wb_ack_out); end
        checks++; if (wb_data_out !== 32'd0) begin errors++; $display("FAIL reset_wbdata got %h want 0", wb_data_out); end
        checks++; if (z80_data_bus_out !== 8'd0) begin errors++; $display("FAIL reset_zdata got %h want 0", z80_data_bus_out); end
        checks++; if (z80_bus_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", z80_bus_dir); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_out); end
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL reset_status got %h want %h", d, exp_status()); end
        wb_rd(c_A_IRQ, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_irqreg got %h want 0", d); end
        wb_rd(c_A_ZB, d);
        checks++; if (d !== 32'h80) begin errors++; $display("FAIL reset_base got %h want 80", d); end
    endtask

    task automatic test_rx_path();
        logic [31:0] d, e;
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        foreach (bytes[i]) begin z80_wr(8'h80, bytes[i]); m_zwrite(bytes[i]); end
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL rx_level got %h want %h", d, exp_status()); end
        for (int i = 0; i < 4; i++) begin
            wb_rd(c_A_DAT, d); m_wbread(e);
            checks++; if (d !== e) begin errors++; $display("FAIL rx_pop%0d got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_tx_path();
        logic [7:0] z, e; logic dir; logic [31:0] d;
        wb_wr(c_A_DAT, 32'hA5); m_wbwrite(8'hA5);
        z80_io(1'b1, 8'h81, 8'h00, z, dir);
        checks++; if (z !== exp_zstatus()) begin errors++; $display("FAIL z80_status got %h want %h", z, exp_zstatus()); end
        z80_io(1'b1, 8'h80, 8'h00, z, dir); m_zread(e);
        checks++; if (z !== e) begin errors++; $display("FAIL tx_pop got %h want %h", z, e); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL tx_dir got %b want 1", dir); end
        checks++; if (z80_bus_dir !== 1'b0) begin errors++; $display("FAIL tx_dir_release got %b want 0", z80_bus_dir); end
        z80_io(1'b1, 8'h80, 8'h00, z, dir); m_zread(e);
        checks++; if (z !== e) begin errors++; $display("FAIL tx_under got %h want %h", z, e); end
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL under_status got %h want %h", d, exp_status()); end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d, e;
        wb_wr(c_A_STA, 32'h7_0000); m_under = 0; m_txovf = 0; m_rxovf = 0;
        for (int i = 0; i < 17; i++) begin z80_wr(8'h80, 8'(8'h40 + i)); m_zwrite(8'(8'h40 + i)); end
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovf_status got %h want %h", d, exp_status()); end
        for (int i = 0; i < 16; i++) begin
            wb_rd(c_A_DAT, d); m_wbread(e);
            checks++; if (d !== e) begin errors++; $display("FAIL ovf_data%0d got %h want %h", i, d, e); end
        end
        wb_wr(c_A_STA, 32'h1_0000); m_rxovf = 0;
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovf_w1c got %h want %h", d, exp_status()); end
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
        wb_wr(c_A_IRQ, 32'h007); m_en = 0; m_pend = 0;
        wb_wr(c_A_IRQ, 32'h101); m_en = 3'b001;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq_out); end
        z80_wr(8'h80, 8'h77); m_zwrite(8'h77);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq_out); end
        wb_rd(c_A_IRQ, d);
        checks++; if (d !== exp_irq()) begin errors++; $display("FAIL irq_reg got %h want %h", d, exp_irq()); end
        wb_wr(c_A_IRQ, 32'h001); m_en = 0; m_pend[0] = 0;
        @(posedge clk); #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq_out); end
        wb_rd(c_A_DAT, d); m_wbread(e);
        checks++; if (d !== e) begin errors++; $display("FAIL irq_drain got %h want %h", d, e); end
    endtask

    task automatic test_base_move();
        logic [31:0] d; int acks;
        wb_wr(c_A_ZB, 32'h40);
        wb_rd(c_A_ZB, d);
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL base_rd got %h want 40", d); end
        z80_wr(8'h80, 8'h99);
        z80_wr(8'h40, 8'h5C); m_zwrite(8'h5C);
        z80_wr(8'h40, 8'h5D); m_zwrite(8'h5D);
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL base_level got %h want %h", d, exp_status()); end
        // Strobe held across the ack cycle and one more: one ack, one pop.
        acks = 0;
        wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = 0; wb_addr_in = c_A_DAT;
        repeat (2) begin @(posedge clk); #1; if (wb_ack_out) acks++; end
        wb_cyc_in = 0; wb_stb_in = 0;
        void'(rx_q.pop_front());
        checks++; if (acks !== 1) begin errors++; $display("FAIL held_acks got %0d want 1", acks); end
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL held_pops got %h want %h", d, exp_status()); end
        wb_wr(c_A_ZB, 32'h80);
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        wb_wr(c_A_DAT, 32'h5A);
        z80_address_bus = 8'h80; z80_ioreq_b = 0; z80_read_strobe_b = 0;
        repeat (5) @(posedge clk); #1;
        checks++; if (z80_bus_dir !== 1'b1) begin errors++; $display("FAIL midrd_dir got %b want 1", z80_bus_dir); end
        reset = 1;
        @(posedge clk); #1;
        checks++; if (z80_bus_dir !== 1'b0) begin errors++; $display("FAIL midrd_reset got %b want 0", z80_bus_dir); end
        z80_read_strobe_b = 1; z80_ioreq_b = 1;
        do_reset();
        wb_rd(c_A_STA, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL midrd_status got %h want %h", d, exp_status()); end
    endtask

    task automatic test_random();
        logic [31:0] d, e; logic [7:0] z, ez, b; logic dir; int op;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            b  = 8'($urandom);
            if (op <= 2) begin
                z80_wr(8'h80, b); m_zwrite(b);
            end else if (op <= 4) begin
                wb_rd(c_A_DAT, d); m_wbread(e);
                checks++; if (d !== e) begin errors++; $display("FAIL rnd_wbpop%0d got %h want %h", n, d, e); end
            end else if (op <= 6) begin
                wb_wr(c_A_DAT, {24'hDEAD00, b}); m_wbwrite(b);
            end else if (op == 7) begin
                z80_io(1'b1, 8'h80, 8'h00, z, dir); m_zread(ez);
                checks++; if (z !== ez) begin errors++; $display("FAIL rnd_zpop%0d got %h want %h", n, z, ez); end
            end else if (op == 8) begin
                wb_rd(c_A_STA, d);
                checks++; if (d !== exp_status()) begin errors++; $display("FAIL rnd_status%0d got %h want %h", n, d, exp_status()); end
                z80_io(1'b1, 8'h81, 8'h00, z, dir);
                checks++; if (z !== exp_zstatus()) begin errors++; $display("FAIL rnd_zstatus%0d got %h want %h", n, z, exp_zstatus()); end
            end else begin
                d = {21'b0, 3'($urandom), 5'b0, 3'($urandom)};
                wb_wr(c_A_IRQ, d); m_en = d[10:8]; m_pend = m_pend & ~d[2:0];
                wb_rd(c_A_IRQ, d);
                checks++; if (d !== exp_irq()) begin errors++; $display("FAIL rnd_irqreg%0d got %h want %h", n, d, exp_irq()); end
            end
            checks++;
            if (irq_out !== |(m_pend & m_en)) begin
                errors++; $display("FAIL rnd_irq%0d got %b want %b", n, irq_out, |(m_pend & m_en));
            end
        end
    endtask

`ifdef ZUBE_FIFO_THRESHOLD_EN
    task automatic test_threshold();
        logic [31:0] d;
        do_reset();
        wb_wr(c_A_THR, 32'h4);
        wb_rd(c_A_THR, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL thr_rd got %h want 4", d); end
        wb_wr(c_A_IRQ, 32'h800);
        for (int k = 1; k <= 4; k++) begin
            z80_wr(8'h80, 8'(k));
            checks++;
            if (irq_out !== (k == 4)) begin errors++; $display("FAIL thr_irq%0d got %b want %b", k, irq_out, k == 4); end
        end
        wb_rd(c_A_IRQ, d);
        checks++; if (d !== 32'h809) begin errors++; $display("FAIL thr_irqreg got %h want 809", d); end
    endtask
`else
    task automatic test_threshold();
        logic [31:0] d; logic a;
        do_reset();
        wb_xfer(1'b0, c_A_THR, 32'd0, d, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL thr_unmapped got %b want 0", a); end
        wb_wr(c_A_IRQ, 32'h80F); m_en = 0; m_pend = 0;
        wb_rd(c_A_IRQ, d);
        checks++; if (d !== exp_irq()) begin errors++; $display("FAIL thr_bit3 got %h want %h", d, exp_irq()); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_rx_path();
        test_tx_path();
        test_rx_overflow();
        test_irq();
        test_base_move();
        test_reset_mid_read();
        test_random();
        test_threshold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
